// File: rtl/buzz_pkg.sv
// Shared source ids, FSM encoding and per-source pattern lookup for the buzzer arbiter.
package buzz_pkg;

   localparam int CNT_W = 32;   // on/off phase counter width
   localparam int HP_W  = 24;   // half-period divider width
   localparam int REP_W = 4;    // burst repeat counter width

   localparam logic [1:0] SRC_CLICK = 2'd0;
   localparam logic [1:0] SRC_SUCC  = 2'd1;
   localparam logic [1:0] SRC_FAIL  = 2'd2;
   localparam logic [1:0] SRC_ALARM = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   typedef struct packed {
      logic [HP_W-1:0]  hp;
      logic [CNT_W-1:0] on;
      logic [CNT_W-1:0] off;
      logic [REP_W-1:0] rep;
   } src_cfg_t;

   // Select the tone/gap pattern that belongs to a source.
   function automatic src_cfg_t cfg_lookup(input logic [1:0] src,
                                           input src_cfg_t c_click,
                                           input src_cfg_t c_succ,
                                           input src_cfg_t c_fail,
                                           input src_cfg_t c_alarm);
      src_cfg_t c;
      case (src)
         SRC_CLICK: c = c_click;
         SRC_SUCC:  c = c_succ;
         SRC_FAIL:  c = c_fail;
         SRC_ALARM: c = c_alarm;
         default:   c = c_click;
      endcase
      return c;
   endfunction

   // Priority encoder: highest-index set bit wins (alarm beats everything).
   function automatic logic [1:0] top_src(input logic [3:0] v);
      logic [1:0] s;
      if (v[3]) begin
         s = SRC_ALARM;
      end else if (v[2]) begin
         s = SRC_FAIL;
      end else if (v[1]) begin
         s = SRC_SUCC;
      end else begin
         s = SRC_CLICK;
      end
      return s;
   endfunction

   // One-hot mask of a source index.
   function automatic logic [3:0] src_mask(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/buzz_tone_gen.sv
// Half-period divider producing the square wave that drives the piezo.
// load starts a fresh tone high, clear holds it silent, en advances the divider.
module buzz_tone_gen
   import buzz_pkg::*;
(
   input  logic            clk,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic            en_i,
   input  logic [HP_W-1:0] hp_i,
   output logic            wave_o
);

   logic [HP_W-1:0] cnt_q, cnt_d;
   logic            wave_q, wave_d;

   // Next divider count and wave level; load wins over clear, clear over enable.
   always_comb begin
      cnt_d  = cnt_q;
      wave_d = wave_q;
      if (load_i) begin
         cnt_d  = '0;
         wave_d = 1'b1;
      end else if (clear_i) begin
         cnt_d  = '0;
         wave_d = 1'b0;
      end else if (en_i) begin
         if (cnt_q == hp_i - HP_W'(1)) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
         end else begin
            cnt_d  = cnt_q + HP_W'(1);
            wave_d = wave_q;
         end
      end else begin
         cnt_d  = cnt_q;
         wave_d = wave_q;
      end
   end

   // Divider and wave registers.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         wave_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wave_q <= wave_d;
      end
   end

   assign wave_o = wave_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// Shares one piezo buzzer between click, success, fail and alarm requesters.
// Fixed priority with preemption; each source plays ON/OFF bursts REP times.
// All timing parameters are in clk cycles.
module buzzer_arbiter
   import buzz_pkg::*;
#(
   parameter int unsigned CLICK_HP  = 50_000,
   parameter int unsigned CLICK_ON  = 10_000_000,
   parameter int unsigned CLICK_OFF = 1,
   parameter int unsigned CLICK_REP = 1,
   parameter int unsigned SUCC_HP   = 25_000,
   parameter int unsigned SUCC_ON   = 30_000_000,
   parameter int unsigned SUCC_OFF  = 1,
   parameter int unsigned SUCC_REP  = 1,
   parameter int unsigned FAIL_HP   = 100_000,
   parameter int unsigned FAIL_ON   = 5_000_000,
   parameter int unsigned FAIL_OFF  = 5_000_000,
   parameter int unsigned FAIL_REP  = 2,
   parameter int unsigned ALARM_HP  = 12_500,
   parameter int unsigned ALARM_ON  = 5_000_000,
   parameter int unsigned ALARM_OFF = 5_000_000,
   parameter int unsigned ALARM_REP = 10
)(
   input  logic       clk,
   input  logic       RSTn,
   input  logic [3:0] req,
   input  logic       mute,
   output logic       buzzer,
   output logic       busy,
   output logic [1:0] active_src,
   output logic       done
);

   localparam src_cfg_t CFG_CLICK = '{hp: HP_W'(CLICK_HP), on: CNT_W'(CLICK_ON),
                                      off: CNT_W'(CLICK_OFF), rep: REP_W'(CLICK_REP)};
   localparam src_cfg_t CFG_SUCC  = '{hp: HP_W'(SUCC_HP), on: CNT_W'(SUCC_ON),
                                      off: CNT_W'(SUCC_OFF), rep: REP_W'(SUCC_REP)};
   localparam src_cfg_t CFG_FAIL  = '{hp: HP_W'(FAIL_HP), on: CNT_W'(FAIL_ON),
                                      off: CNT_W'(FAIL_OFF), rep: REP_W'(FAIL_REP)};
   localparam src_cfg_t CFG_ALARM = '{hp: HP_W'(ALARM_HP), on: CNT_W'(ALARM_ON),
                                      off: CNT_W'(ALARM_OFF), rep: REP_W'(ALARM_REP)};

   // Only success/fail/alarm may wait; a click that cannot play is dropped.
   localparam logic [3:0] PEND_OK = 4'b1110;

   state_e           state_q, state_d;
   logic [1:0]       active_q, active_d;
   logic [CNT_W-1:0] ph_q, ph_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [3:0]       pend_q, pend_d;
   logic             done_q, done_d;

   src_cfg_t         cfg_s;
   logic             load_s, clear_s, en_s, wave_s;
   logic [3:0]       cand_s, pend_lo_s;
   logic [1:0]       req_top_s, cand_top_s, pend_top_s;
   logic             preempt_s, ph_last_s, gap_last_s, rep_last_s;

   assign cfg_s = cfg_lookup(active_q, CFG_CLICK, CFG_SUCC, CFG_FAIL, CFG_ALARM);

   buzz_tone_gen u_tone (
      .clk     (clk),
      .rst_ni  (RSTn),
      .load_i  (load_s),
      .clear_i (clear_s),
      .en_i    (en_s),
      .hp_i    (cfg_s.hp),
      .wave_o  (wave_s)
   );

   // Arbitration, pattern sequencing and pending bookkeeping.
   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      ph_d       = ph_q;
      rep_d      = rep_q;
      pend_d     = pend_q;
      done_d     = 1'b0;
      load_s     = 1'b0;
      clear_s    = 1'b0;
      en_s       = 1'b0;
      cand_s     = req | pend_q;
      pend_lo_s  = pend_q | (req & PEND_OK);
      req_top_s  = top_src(req);
      cand_top_s = top_src(cand_s);
      pend_top_s = top_src(pend_lo_s);
      preempt_s  = (req != 4'b0000) && (req_top_s >= active_q);
      ph_last_s  = (ph_q == cfg_s.on - CNT_W'(1));
      gap_last_s = (ph_q == cfg_s.off - CNT_W'(1));
      rep_last_s = (rep_q == cfg_s.rep - REP_W'(1));

      if ((state_q != ST_IDLE) && preempt_s) begin
         // Higher (or same) source restarts immediately; old pattern is discarded.
         state_d  = ST_TONE;
         active_d = req_top_s;
         ph_d     = '0;
         rep_d    = '0;
         pend_d   = pend_lo_s & ~src_mask(req_top_s);
         load_s   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               clear_s = 1'b1;
               if (cand_s != 4'b0000) begin
                  state_d  = ST_TONE;
                  active_d = cand_top_s;
                  ph_d     = '0;
                  rep_d    = '0;
                  pend_d   = cand_s & PEND_OK & ~src_mask(cand_top_s);
                  load_s   = 1'b1;
               end else begin
                  pend_d = pend_q;
               end
            end
            ST_TONE: begin
               pend_d = pend_lo_s;
               if (ph_last_s) begin
                  ph_d = '0;
                  if (!rep_last_s) begin
                     state_d = ST_GAP;
                     clear_s = 1'b1;
                  end else begin
                     done_d = 1'b1;
                     rep_d  = '0;
                     if (pend_lo_s != 4'b0000) begin
                        // Hand over straight to the next waiting source.
                        state_d  = ST_TONE;
                        active_d = pend_top_s;
                        pend_d   = pend_lo_s & ~src_mask(pend_top_s);
                        load_s   = 1'b1;
                     end else begin
                        state_d  = ST_IDLE;
                        active_d = SRC_CLICK;
                        clear_s  = 1'b1;
                     end
                  end
               end else begin
                  ph_d = ph_q + CNT_W'(1);
                  en_s = 1'b1;
               end
            end
            ST_GAP: begin
               pend_d = pend_lo_s;
               if (gap_last_s) begin
                  state_d = ST_TONE;
                  ph_d    = '0;
                  rep_d   = rep_q + REP_W'(1);
                  load_s  = 1'b1;
               end else begin
                  ph_d    = ph_q + CNT_W'(1);
                  clear_s = 1'b1;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               active_d = SRC_CLICK;
               ph_d     = '0;
               rep_d    = '0;
               pend_d   = 4'b0000;
               clear_s  = 1'b1;
            end
         endcase
      end
   end

   // FSM state, phase/repeat counters, pending set and done pulse.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= ST_IDLE;
         active_q <= SRC_CLICK;
         ph_q     <= '0;
         rep_q    <= '0;
         pend_q   <= 4'b0000;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         ph_q     <= ph_d;
         rep_q    <= rep_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
      end
   end

   // Mute gates the registered wave only; sequencing is unaffected.
   assign buzzer     = wave_s & ~mute;
   assign busy       = (state_q != ST_IDLE);
   assign active_src = active_q;
   assign done       = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with short patterns: HP=2, ON=8, OFF=4,
// REP click/succ=1, fail=2, alarm=3.
module tb_buzzer_arbiter;

   logic       clk = 1'b0;
   logic       RSTn;
   logic [3:0] req;
   logic       mute;
   logic       buzzer;
   logic       busy;
   logic [1:0] active_src;
   logic       done;

   int total = 0;
   int bad   = 0;

   // exp packs {buzzer, busy, active_src[1:0], done}
   typedef struct {
      logic [3:0] req;
      logic       mute;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs [11];

   buzzer_arbiter #(
      .CLICK_HP(2), .CLICK_ON(8), .CLICK_OFF(4), .CLICK_REP(1),
      .SUCC_HP(2),  .SUCC_ON(8),  .SUCC_OFF(4),  .SUCC_REP(1),
      .FAIL_HP(2),  .FAIL_ON(8),  .FAIL_OFF(4),  .FAIL_REP(2),
      .ALARM_HP(2), .ALARM_ON(8), .ALARM_OFF(4), .ALARM_REP(3)
   ) dut (
      .clk        (clk),
      .RSTn       (RSTn),
      .req        (req),
      .mute       (mute),
      .buzzer     (buzzer),
      .busy       (busy),
      .active_src (active_src),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic e_buz, input logic e_busy,
                      input logic [1:0] e_src, input logic e_done);
      logic [4:0] act;
      logic [4:0] want;
      act  = {buzzer, busy, active_src, done};
      want = {e_buz, e_busy, e_src, e_done};
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s @%0t: buz/busy/src/done got %b want %b", name, $time, act, want);
      end
   endtask

   // Start a new cycle: inputs change just after the rising edge.
   task automatic tick(input logic [3:0] r, input logic m);
      @(posedge clk);
      #1;
      req  = r;
      mute = m;
      #1;
   endtask

   // Tone cycles k0..k0+n-1 of a burst; wave is high for k%4 in {0,1}.
   task automatic burst(input string name, input logic [1:0] src, input int k0, input int n,
                        input logic m, input int inj_k, input logic [3:0] inj_req);
      for (int k = k0; k < k0 + n; k++) begin
         tick((k == inj_k) ? inj_req : 4'b0000, m);
         chk($sformatf("%s[%0d]", name, k), (((k / 2) % 2) == 0) && !m, 1'b1, src, 1'b0);
      end
   endtask

   task automatic gap(input string name, input logic [1:0] src, input int n);
      for (int k = 0; k < n; k++) begin
         tick(4'b0000, 1'b0);
         chk($sformatf("%s[%0d]", name, k), 1'b0, 1'b1, src, 1'b0);
      end
   endtask

   task automatic idle(input string name, input int n);
      for (int k = 0; k < n; k++) begin
         tick(4'b0000, 1'b0);
         chk($sformatf("%s[%0d]", name, k), 1'b0, 1'b0, 2'd0, 1'b0);
      end
   endtask

   initial begin
      RSTn = 1'b0;
      req  = 4'b0000;
      mute = 1'b0;

      // Click at row 0: tone rows 1..8 (toggle every 2), done at row 9.
      vecs[0]  = '{4'b0001, 1'b0, 5'b00000};
      vecs[1]  = '{4'b0000, 1'b0, 5'b11000};
      vecs[2]  = '{4'b0000, 1'b0, 5'b11000};
      vecs[3]  = '{4'b0000, 1'b0, 5'b01000};
      vecs[4]  = '{4'b0000, 1'b0, 5'b01000};
      vecs[5]  = '{4'b0000, 1'b0, 5'b11000};
      vecs[6]  = '{4'b0000, 1'b0, 5'b11000};
      vecs[7]  = '{4'b0000, 1'b0, 5'b01000};
      vecs[8]  = '{4'b0000, 1'b0, 5'b01000};
      vecs[9]  = '{4'b0000, 1'b0, 5'b00001};
      vecs[10] = '{4'b0000, 1'b0, 5'b00000};

      repeat (3) @(posedge clk);
      #1;
      RSTn = 1'b1;
      chk("reset", 1'b0, 1'b0, 2'd0, 1'b0);
      idle("pre", 6);

      // Click pattern from the vector table.
      for (int i = 0; i < 11; i++) begin
         tick(vecs[i].req, vecs[i].mute);
         chk($sformatf("click[%0d]", i), vecs[i].exp[4], vecs[i].exp[3],
             vecs[i].exp[2:1], vecs[i].exp[0]);
      end

      // Fail: two bursts separated by a 4-cycle gap, one done.
      tick(4'b0100, 1'b0);
      chk("fail_req", 1'b0, 1'b0, 2'd0, 1'b0);
      burst("fail_b0", 2'd2, 0, 8, 1'b0, -1, 4'b0000);
      gap("fail_gap", 2'd2, 4);
      burst("fail_b1", 2'd2, 0, 8, 1'b0, -1, 4'b0000);
      tick(4'b0000, 1'b0);
      chk("fail_done", 1'b0, 1'b0, 2'd0, 1'b1);
      idle("fail_after", 2);

      // Click during fail is dropped; nothing follows the fail pattern.
      tick(4'b0100, 1'b0);
      chk("clkdrop_req", 1'b0, 1'b0, 2'd0, 1'b0);
      burst("clkdrop_b0", 2'd2, 0, 8, 1'b0, 3, 4'b0001);
      gap("clkdrop_gap", 2'd2, 4);
      burst("clkdrop_b1", 2'd2, 0, 8, 1'b0, -1, 4'b0000);
      tick(4'b0000, 1'b0);
      chk("clkdrop_done", 1'b0, 1'b0, 2'd0, 1'b1);
      idle("clkdrop_after", 4);

      // Success during fail waits, then starts with no idle cycle.
      tick(4'b0100, 1'b0);
      chk("pend_req", 1'b0, 1'b0, 2'd0, 1'b0);
      burst("pend_fail_b0", 2'd2, 0, 8, 1'b0, 2, 4'b0010);
      gap("pend_fail_gap", 2'd2, 4);
      burst("pend_fail_b1", 2'd2, 0, 8, 1'b0, -1, 4'b0000);
      tick(4'b0000, 1'b0);
      chk("pend_handover", 1'b1, 1'b1, 2'd1, 1'b1);
      burst("pend_succ", 2'd1, 1, 7, 1'b0, -1, 4'b0000);
      tick(4'b0000, 1'b0);
      chk("pend_succ_done", 1'b0, 1'b0, 2'd0, 1'b1);
      idle("pend_after", 2);

      // Muted success: silent, but done lands on the same cycle.
      tick(4'b0010, 1'b1);
      chk("mute_req", 1'b0, 1'b0, 2'd0, 1'b0);
      burst("mute_succ", 2'd1, 0, 8, 1'b1, -1, 4'b0000);
      tick(4'b0000, 1'b1);
      chk("mute_done", 1'b0, 1'b0, 2'd0, 1'b1);
      idle("mute_after", 2);

      // Alarm preempts fail at its 5th tone cycle; fail is discarded.
      tick(4'b0100, 1'b0);
      chk("preempt_req", 1'b0, 1'b0, 2'd0, 1'b0);
      burst("preempt_fail", 2'd2, 0, 5, 1'b0, 4, 4'b1000);
      for (int r = 0; r < 3; r++) begin
         burst($sformatf("alarm_b%0d", r), 2'd3, 0, 8, 1'b0, -1, 4'b0000);
         if (r < 2) begin
            gap($sformatf("alarm_gap%0d", r), 2'd3, 4);
         end
      end
      tick(4'b0000, 1'b0);
      chk("alarm_done", 1'b0, 1'b0, 2'd0, 1'b1);
      idle("alarm_after", 3);

      // Reset mid-alarm silences at once; no done ever appears afterwards.
      tick(4'b1000, 1'b0);
      chk("rst_req", 1'b0, 1'b0, 2'd0, 1'b0);
      burst("rst_b0", 2'd3, 0, 8, 1'b0, -1, 4'b0000);
      gap("rst_gap", 2'd3, 4);
      burst("rst_b1", 2'd3, 0, 2, 1'b0, -1, 4'b0000);
      #3;
      RSTn = 1'b0;
      #1;
      chk("rst_async", 1'b0, 1'b0, 2'd0, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_hold", 1'b0, 1'b0, 2'd0, 1'b0);
      RSTn = 1'b1;
      idle("rst_after", 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
